// File: rtl/snake_pkg.sv
// snake_pkg: cell encodings, grid defaults, read-tag encoding and arbiter states shared by the VRAM blocks.
// rev 1.0
`default_nettype none

package snake_pkg;

  localparam logic [1:0] CELL_NONE  = 2'd0;
  localparam logic [1:0] CELL_BODY  = 2'd1;
  localparam logic [1:0] CELL_BRICK = 2'd2;
  localparam logic [1:0] CELL_APPLE = 2'd3;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int ROW_DEF = 25;
  localparam int COL_DEF = 15;

  localparam logic TAG_RENDER = 1'b0;
  localparam logic TAG_GAME   = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // A VRAM cell is {dir, type}.
  function automatic logic [3:0] make_cell(input logic [1:0] dir, input logic [1:0] kind);
    return {dir, kind};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_rd_tagpipe.sv
// vram_rd_tagpipe: DEPTH-deep valid+tag shift register tracking reads in flight through the VRAM.
// rev 1.0
`default_nettype none

module vram_rd_tagpipe #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_tag
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] tag [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_tag   = tag[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the cell VRAM between render reads, game read/write and a bulk-clear fill.
// rev 1.0 -- optional address bound check with sticky addr_err when VRAM_BOUND_CHK_EN is defined.
`default_nettype none

module vram_arbiter
  import snake_pkg::*;
#(
  parameter int         ROW        = ROW_DEF,
  parameter int         COL        = COL_DEF,
  parameter int         AW         = 9,
  parameter int         RD_LAT     = 5,
  parameter logic [3:0] STARVE_MAX = 4'd8,
  parameter logic [3:0] CLR_DATA   = {DIR_RIGHT, CELL_NONE}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic [3:0]    r_rdata,
  output logic          r_rvalid,
  output logic          r_miss,
  input  logic          g_req,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [3:0]    g_wdata,
  output logic          g_gnt,
  output logic [3:0]    g_rdata,
  output logic          g_rvalid,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] waddr,
  output logic [3:0]    di,
  output logic          we,
  input  logic [3:0]    vdo
`ifdef VRAM_BOUND_CHK_EN
  ,
  output logic          addr_err
`endif
);

  localparam int            NCELL    = ROW * COL;
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] CELL_END = CW'(NCELL);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] clr_cnt, clr_cnt_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic          done_nxt;
  logic          we_nxt;
  logic [AW-1:0] waddr_nxt;
  logic [3:0]    di_nxt;
  logic [AW-1:0] raddr_nxt;
  logic          rd_acc;
  logic          rd_tag;
  logic          rd_blank;
  logic          r_ok;
  logic          g_ok;
  logic          game_open;
  logic          g_rd_pend;
  logic          r_want;
  logic          forced;
  logic          pipe_vld;
  logic [1:0]    pipe_out;

`ifdef VRAM_BOUND_CHK_EN
  assign r_ok = ({1'b0, r_addr} < CELL_END);
  assign g_ok = ({1'b0, g_addr} < CELL_END);
`else
  assign r_ok = 1'b1;
  assign g_ok = 1'b1;
`endif

  // The clear owns the write port, so a clr_start cycle grants the game nothing.
  assign game_open = (state == ST_IDLE) && !clr_start;
  assign g_rd_pend = game_open && g_req && !g_we;
  assign r_want    = r_req && r_ok;
  assign forced    = g_rd_pend && (starve_cnt >= STARVE_MAX);
  assign clr_busy  = (state == ST_CLEAR);

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    done_nxt    = 1'b0;
    we_nxt      = 1'b0;
    waddr_nxt   = waddr;
    di_nxt      = di;
    starve_nxt  = starve_cnt;
    raddr_nxt   = raddr;
    rd_acc      = 1'b0;
    rd_tag      = TAG_RENDER;
    rd_blank    = 1'b0;
    g_gnt       = 1'b0;
    r_miss      = r_req && !r_ok;

    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = CW'(1);
          we_nxt      = 1'b1;
          waddr_nxt   = '0;
          di_nxt      = CLR_DATA;
        end else if (g_req && g_we) begin
          g_gnt = 1'b1;
          if (g_ok) begin
            we_nxt    = 1'b1;
            waddr_nxt = g_addr;
            di_nxt    = g_wdata;
          end
        end
      end
      ST_CLEAR: begin
        // clr_cnt is the next address to issue; reaching CELL_END means the fill is on the port.
        if (clr_cnt == CELL_END) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          we_nxt      = 1'b1;
          waddr_nxt   = clr_cnt[AW-1:0];
          di_nxt      = CLR_DATA;
          clr_cnt_nxt = clr_cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (forced) begin
      g_gnt      = 1'b1;
      rd_acc     = 1'b1;
      rd_tag     = TAG_GAME;
      starve_nxt = '0;
      if (r_req) r_miss = 1'b1;
    end else if (r_want) begin
      rd_acc = 1'b1;
      rd_tag = TAG_RENDER;
      if (g_rd_pend && starve_cnt < STARVE_MAX) starve_nxt = starve_cnt + 4'd1;
    end else if (g_rd_pend) begin
      g_gnt      = 1'b1;
      rd_acc     = 1'b1;
      rd_tag     = TAG_GAME;
      starve_nxt = '0;
    end

    if (rd_acc) begin
      if (rd_tag == TAG_RENDER) begin
        raddr_nxt = r_addr;
      end else if (g_ok) begin
        raddr_nxt = g_addr;
      end else begin
        rd_blank = 1'b1;
      end
    end
  end

  vram_rd_tagpipe #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_tagpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_tag    ({rd_blank, rd_tag}),
    .out_valid (pipe_vld),
    .out_tag   (pipe_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      clr_done   <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      di         <= '0;
      raddr      <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      g_rvalid   <= 1'b0;
      g_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      starve_cnt <= starve_nxt;
      clr_done   <= done_nxt;
      we         <= we_nxt;
      waddr      <= waddr_nxt;
      di         <= di_nxt;
      raddr      <= raddr_nxt;
      r_rvalid   <= pipe_vld && (pipe_out[0] == TAG_RENDER);
      g_rvalid   <= pipe_vld && (pipe_out[0] == TAG_GAME);
      if (pipe_vld) begin
        if (pipe_out[0] == TAG_RENDER) r_rdata <= pipe_out[1] ? 4'h0 : vdo;
        else                           g_rdata <= pipe_out[1] ? 4'h0 : vdo;
      end
    end
  end

`ifdef VRAM_BOUND_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else if ((r_req && !r_ok) || (g_gnt && !g_ok)) begin
      addr_err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural VRAM model.
// rev 1.0
`default_nettype none

module tb_vram_arbiter;
  import snake_pkg::*;

  localparam int AW     = 9;
  localparam int RD_LAT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_rdata;
  logic          r_rvalid;
  logic          r_miss;
  logic          g_req;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [3:0]    g_wdata;
  logic          g_gnt;
  logic [3:0]    g_rdata;
  logic          g_rvalid;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [3:0]    di;
  logic          we;
  logic [3:0]    vdo;
`ifdef VRAM_BOUND_CHK_EN
  logic          addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .r_req     (r_req),
    .r_addr    (r_addr),
    .r_rdata   (r_rdata),
    .r_rvalid  (r_rvalid),
    .r_miss    (r_miss),
    .g_req     (g_req),
    .g_we      (g_we),
    .g_addr    (g_addr),
    .g_wdata   (g_wdata),
    .g_gnt     (g_gnt),
    .g_rdata   (g_rdata),
    .g_rvalid  (g_rvalid),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .raddr     (raddr),
    .waddr     (waddr),
    .di        (di),
    .we        (we),
    .vdo       (vdo)
`ifdef VRAM_BOUND_CHK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  // VRAM model: write on the edge, read data appears RD_LAT edges after raddr is launched.
  logic [3:0] mem   [512];
  logic [3:0] rpipe [RD_LAT-1];
  logic       pre_en = 1'b0;

  always @(posedge clk) begin
    if (pre_en) for (int i = 0; i < 512; i++) mem[i] <= i[3:0];
    if (we) mem[waddr] <= di;
    rpipe[0] <= mem[raddr];
    for (int i = 1; i < RD_LAT-1; i++) rpipe[i] <= rpipe[i-1];
  end
  assign vdo = rpipe[RD_LAT-2];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [39:0] v;
    rst = 1'b0; r_req = 1'b0; r_addr = '0; g_req = 1'b0; g_we = 1'b0;
    g_addr = '0; g_wdata = '0; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = {4'h0, raddr, waddr, di, we, r_rdata, r_rvalid, r_miss, g_gnt, g_rdata, g_rvalid, clr_busy, clr_done};
    n_checks++;
    if (v !== 40'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", v); end
`ifdef VRAM_BOUND_CHK_EN
    n_checks++;
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
`endif
    next_cycle;
    rst = 1'b1;
    next_cycle;
  endtask

  task automatic test_clear;
    int bad = 0;
    clr_start = 1'b1;
    next_cycle;
    clr_start = 1'b0;
    for (int k = 1; k <= 375; k++) begin
      @(negedge clk);
      if (we !== 1'b1 || waddr !== 9'(k-1) || di !== 4'h0 || clr_busy !== 1'b1 || clr_done !== 1'b0) bad++;
      next_cycle;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clear_sequence: %0d bad cycles, required 0", bad); end
    @(negedge clk);
    n_checks++;
    if (clr_done !== 1'b1) begin n_fail++; $display("FAIL clear_done: got %b expected 1 at cycle 376", clr_done); end
    n_checks++;
    if (clr_busy !== 1'b0 || we !== 1'b0) begin
      n_fail++; $display("FAIL clear_end: busy=%b we=%b expected 0 0", clr_busy, we);
    end
    next_cycle;
    @(negedge clk);
    n_checks++;
    if (clr_done !== 1'b0) begin n_fail++; $display("FAIL clear_done_pulse: got %b expected 0", clr_done); end
    next_cycle;
  endtask

  task automatic preload;
    pre_en = 1'b1;
    next_cycle;
    pre_en = 1'b0;
    next_cycle;
  endtask

  task automatic test_render_stream;
    int first = -1, nvalid = 0, bad = 0, misses = 0;
    for (int k = 0; k < 20; k++) begin
      r_req  = (k < 10);
      r_addr = 9'(k);
      @(negedge clk);
      if (r_miss) misses++;
      if (g_rvalid) bad++;
      if (r_rvalid) begin
        if (first < 0) first = k;
        if (r_rdata !== 4'(nvalid)) bad++;
        nvalid++;
      end
      next_cycle;
    end
    r_req = 1'b0;
    n_checks++;
    if (first != 6) begin n_fail++; $display("FAIL stream_first_valid: got cycle %0d expected 6", first); end
    n_checks++;
    if (nvalid != 10) begin n_fail++; $display("FAIL stream_count: got %0d expected 10", nvalid); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stream_data: %0d bad beats, required 0", bad); end
    n_checks++;
    if (misses != 0) begin n_fail++; $display("FAIL stream_miss: got %0d expected 0", misses); end
  endtask

  task automatic test_starve;
    int gc = -1, mc = -1, misses = 0, ngnt = 0, vc = -1;
    logic [3:0] gd = 4'hx;
    g_req = 1'b1; g_we = 1'b0; g_addr = 9'd40;
    for (int k = 0; k < 30; k++) begin
      r_req  = 1'b1;
      r_addr = 9'(100 + k);
      @(negedge clk);
      if (g_gnt) begin ngnt++; if (gc < 0) gc = k; end
      if (r_miss) begin misses++; mc = k; end
      if (g_rvalid && vc < 0) begin vc = k; gd = g_rdata; end
      next_cycle;
      if (gc >= 0) g_req = 1'b0;
    end
    r_req = 1'b0;
    repeat (8) next_cycle;
    n_checks++;
    if (gc != 8) begin n_fail++; $display("FAIL starve_gnt_cycle: got %0d expected 8", gc); end
    n_checks++;
    if (ngnt != 1) begin n_fail++; $display("FAIL starve_gnt_count: got %0d expected 1", ngnt); end
    n_checks++;
    if (misses != 1 || mc != 8) begin
      n_fail++; $display("FAIL starve_miss: got %0d misses last at %0d expected 1 at 8", misses, mc);
    end
    n_checks++;
    if (vc != 14) begin n_fail++; $display("FAIL starve_rvalid_cycle: got %0d expected 14", vc); end
    n_checks++;
    if (gd !== 4'h8) begin n_fail++; $display("FAIL starve_rdata: got %h expected 8", gd); end
  endtask

  task automatic test_rbw;
    logic [3:0] d6 = 4'hx, d8 = 4'hx;
    logic       v6 = 1'b0, v8 = 1'b0;
    g_req = 1'b1; g_we = 1'b1; g_addr = 9'd12; g_wdata = 4'h3;
    r_req = 1'b1; r_addr = 9'd12;
    @(negedge clk);
    n_checks++;
    if (g_gnt !== 1'b1) begin n_fail++; $display("FAIL rbw_wr_gnt: got %b expected 1", g_gnt); end
    next_cycle;
    g_req = 1'b0; g_we = 1'b0; r_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || waddr !== 9'd12 || di !== 4'h3) begin
      n_fail++; $display("FAIL rbw_wr_port: we=%b waddr=%0d di=%h expected 1 12 3", we, waddr, di);
    end
    next_cycle;
    r_req = 1'b1; r_addr = 9'd12;
    next_cycle;
    r_req = 1'b0;
    for (int k = 3; k < 12; k++) begin
      @(negedge clk);
      if (k == 6) begin v6 = r_rvalid; d6 = r_rdata; end
      if (k == 8) begin v8 = r_rvalid; d8 = r_rdata; end
      next_cycle;
    end
    n_checks++;
    if (v6 !== 1'b1 || d6 !== 4'hC) begin
      n_fail++; $display("FAIL rbw_old_data: valid=%b data=%h expected 1 C", v6, d6);
    end
    n_checks++;
    if (v8 !== 1'b1 || d8 !== 4'h3) begin
      n_fail++; $display("FAIL rbw_new_data: valid=%b data=%h expected 1 3", v8, d8);
    end
  endtask

`ifdef VRAM_BOUND_CHK_EN
  task automatic test_bound;
    int vc = -1;
    logic [3:0] gd = 4'hx;
    g_req = 1'b1; g_we = 1'b1; g_addr = 9'd400; g_wdata = 4'h5;
    @(negedge clk);
    n_checks++;
    if (g_gnt !== 1'b1) begin n_fail++; $display("FAIL bound_wr_gnt: got %b expected 1", g_gnt); end
    next_cycle;
    g_req = 1'b0; g_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we !== 1'b0 || addr_err !== 1'b1) begin
      n_fail++; $display("FAIL bound_wr_blocked: we=%b addr_err=%b expected 0 1", we, addr_err);
    end
    next_cycle;
    r_req = 1'b1; r_addr = 9'd400;
    @(negedge clk);
    n_checks++;
    if (r_miss !== 1'b1) begin n_fail++; $display("FAIL bound_r_miss: got %b expected 1", r_miss); end
    next_cycle;
    r_req = 1'b0;
    g_req = 1'b1; g_addr = 9'd401;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (g_rvalid && vc < 0) begin vc = k; gd = g_rdata; end
      next_cycle;
      g_req = 1'b0;
    end
    n_checks++;
    if (vc != 6 || gd !== 4'h0) begin
      n_fail++; $display("FAIL bound_rd_zero: cycle=%0d data=%h expected 6 0", vc, gd);
    end
    n_checks++;
    if (addr_err !== 1'b1) begin n_fail++; $display("FAIL bound_sticky: got %b expected 1", addr_err); end
  endtask
`endif

  task automatic test_clear_block;
    int dc = -1, gc = -1, rvc = -1, gvc = -1;
    logic [3:0] rd = 4'hx, gd = 4'hx;
    clr_start = 1'b1;
    for (int k = 0; k < 390; k++) begin
      if (k == 1) clr_start = 1'b0;
      r_req  = (k == 5);
      r_addr = 9'd7;
      if (k == 10) begin g_req = 1'b1; g_we = 1'b0; g_addr = 9'd40; end
      @(negedge clk);
      if (clr_done && dc < 0) dc = k;
      if (g_gnt && gc < 0) gc = k;
      if (r_rvalid && rvc < 0) begin rvc = k; rd = r_rdata; end
      if (g_rvalid && gvc < 0) begin gvc = k; gd = g_rdata; end
      next_cycle;
      if (gc >= 0) g_req = 1'b0;
    end
    r_req = 1'b0;
    n_checks++;
    if (dc != 376) begin n_fail++; $display("FAIL blk_done_cycle: got %0d expected 376", dc); end
    n_checks++;
    if (gc != 376) begin n_fail++; $display("FAIL blk_gnt_cycle: got %0d expected 376", gc); end
    n_checks++;
    if (rvc != 11 || rd !== 4'h7) begin
      n_fail++; $display("FAIL blk_render_read: cycle=%0d data=%h expected 11 7", rvc, rd);
    end
    n_checks++;
    if (gvc != 382 || gd !== 4'h0) begin
      n_fail++; $display("FAIL blk_game_read: cycle=%0d data=%h expected 382 0", gvc, gd);
    end
  endtask

  task automatic test_reset_mid_clear;
    int dn = 0, rv = 0, wn = 0, bz = 0;
    logic [39:0] v;
    clr_start = 1'b1;
    next_cycle;
    clr_start = 1'b0;
    repeat (47) next_cycle;
    r_req = 1'b1; r_addr = 9'd3;
    next_cycle;
    r_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || clr_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_clear_active: we=%b busy=%b expected 1 1", we, clr_busy);
    end
    next_cycle;
    rst = 1'b0;
    @(negedge clk);
    v = {4'h0, raddr, waddr, di, we, r_rdata, r_rvalid, r_miss, g_gnt, g_rdata, g_rvalid, clr_busy, clr_done};
    n_checks++;
    if (v !== 40'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", v); end
    next_cycle;
    rst = 1'b1;
`ifdef VRAM_BOUND_CHK_EN
    @(negedge clk);
    n_checks++;
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_addr_err: got %b expected 0", addr_err); end
`endif
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (clr_done) dn++;
      if (r_rvalid || g_rvalid) rv++;
      if (we) wn++;
      if (clr_busy) bz++;
      next_cycle;
    end
    n_checks++;
    if (dn != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses expected 0", dn); end
    n_checks++;
    if (rv != 0) begin n_fail++; $display("FAIL mid_no_rvalid: got %0d expected 0", rv); end
    n_checks++;
    if (wn != 0 || bz != 0) begin
      n_fail++; $display("FAIL mid_idle: we cycles=%0d busy cycles=%0d expected 0 0", wn, bz);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    preload();
    test_render_stream();
    test_starve();
    test_rbw();
`ifdef VRAM_BOUND_CHK_EN
    test_bound();
`endif
    test_clear_block();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
